// File: rtl/router_pkg.sv
// Shared defaults and header field positions for the router packet datapath.
package router_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int ADDR_W_DEF   = 2;
  localparam int HDR_ADDR_LSB = 0;

endpackage

// File: rtl/router_pkt_parity.sv
// Running parity accumulator: seeded with the header, folded with each payload,
// compared against the received parity byte to produce a sticky err flag.
module router_pkt_parity
  import router_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit ODD_PAR = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              seed,
  input  logic [DATA_W-1:0] seed_val,
  input  logic              fold,
  input  logic [DATA_W-1:0] fold_val,
  input  logic              clear,
  input  logic              check,
  input  logic [DATA_W-1:0] pkt_parity,
  output logic [DATA_W-1:0] int_parity,
  output logic              err
);

  function automatic logic [DATA_W-1:0] expected_parity(input logic [DATA_W-1:0] acc);
    if (ODD_PAR) begin
      return ~acc;
    end else begin
      return acc;
    end
  endfunction

  logic mismatch;

  // compare received parity against the accumulated value
  always_comb begin
    mismatch = (pkt_parity != expected_parity(int_parity));
  end

  // accumulator and sticky error flag; a new header clear wins over a check
  always_ff @(posedge clock) begin
    if (reset) begin
      int_parity <= {DATA_W{1'b0}};
      err        <= 1'b0;
    end else begin
      if (seed) begin
        int_parity <= seed_val;
      end else if (fold) begin
        int_parity <= int_parity ^ fold_val;
      end
      if (clear) begin
        err <= 1'b0;
      end else if (check) begin
        err <= mismatch;
      end
    end
  end

endmodule

// File: rtl/router_pkt_reg.sv
// Router packet register: header/hold capture, output byte, parity and length
// checking. Optional error counter enabled by ROUTER_PKT_REG_ERR_CNT_EN.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ODD_PAR = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err,
  output logic [15:0]       err_cnt
);

  localparam int LEN_W = DATA_W - ADDR_W;
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  logic [DATA_W-1:0] header_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] pkt_parity;
  logic [DATA_W-1:0] int_parity;
  logic [DATA_W-1:0] fold_val;
  logic [LEN_W-1:0]  payload_cnt;
  logic              hold_valid;
  logic              parity_done_d;
  logic              new_hdr, seed, fold_in, fold_hold, fold, hold_cap, par_cap, check, len_bad;

  // decode the one-hot state inputs into datapath enables
  always_comb begin
    new_hdr   = detect_add && pkt_valid &&
                (data_in[HDR_ADDR_LSB +: ADDR_W] != {ADDR_W{1'b1}});
    seed      = lfd_state && !full_state;
    fold_in   = ld_state && !full_state && !fifo_full && pkt_valid;
    fold_hold = laf_state && !full_state && hold_valid;
    fold      = fold_in || fold_hold;
    hold_cap  = ld_state && fifo_full && pkt_valid;
    par_cap   = ld_state && !full_state && !pkt_valid && !parity_done && !low_pkt_valid;
    check     = parity_done && !parity_done_d && !detect_add && !full_state;
    len_bad   = (payload_cnt != header_reg[DATA_W-1:ADDR_W]);
    if (fold_hold) begin
      fold_val = hold_reg;
    end else begin
      fold_val = data_in;
    end
  end

  // header/hold capture, output byte and payload count
  always_ff @(posedge clock) begin
    if (reset) begin
      header_reg  <= {DATA_W{1'b0}};
      hold_reg    <= {DATA_W{1'b0}};
      hold_valid  <= 1'b0;
      dout        <= {DATA_W{1'b0}};
      payload_cnt <= {LEN_W{1'b0}};
    end else if (!full_state) begin
      if (new_hdr) begin
        header_reg <= data_in;
      end
      // hold_valid makes the laf fold happen once, and never for a deferred parity beat
      if (hold_cap) begin
        hold_reg   <= data_in;
        hold_valid <= 1'b1;
      end else if (fold_hold || detect_add) begin
        hold_valid <= 1'b0;
      end
      if (seed) begin
        dout        <= header_reg;
        payload_cnt <= {LEN_W{1'b0}};
      end else if (fold) begin
        dout <= fold_val;
        if (payload_cnt != CNT_MAX) begin
          payload_cnt <= payload_cnt + CNT_ONE;
        end
      end
    end
  end

  // parity beat capture and end-of-packet status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_parity    <= {DATA_W{1'b0}};
      parity_done   <= 1'b0;
      parity_done_d <= 1'b0;
      low_pkt_valid <= 1'b0;
      len_err       <= 1'b0;
    end else if (!full_state) begin
      parity_done_d <= parity_done;
      if (par_cap) begin
        pkt_parity <= data_in;
      end
      if (detect_add) begin
        parity_done <= 1'b0;
      end else if (par_cap && !fifo_full) begin
        parity_done <= 1'b1;
      end else if (laf_state && low_pkt_valid && !parity_done) begin
        parity_done <= 1'b1;
      end
      if (rst_int_reg) begin
        low_pkt_valid <= 1'b0;
      end else if (par_cap && fifo_full) begin
        low_pkt_valid <= 1'b1;
      end
      if (detect_add) begin
        len_err <= 1'b0;
      end else if (check) begin
        len_err <= len_bad;
      end
    end
  end

  router_pkt_parity #(
    .DATA_W  (DATA_W),
    .ODD_PAR (ODD_PAR)
  ) u_parity (
    .clock      (clock),
    .reset      (reset),
    .seed       (seed),
    .seed_val   (header_reg),
    .fold       (fold),
    .fold_val   (fold_val),
    .clear      (detect_add),
    .check      (check),
    .pkt_parity (pkt_parity),
    .int_parity (int_parity),
    .err        (err)
  );

`ifdef ROUTER_PKT_REG_ERR_CNT_EN
  logic any_err_d;

  // count each packet whose err or len_err goes high, saturating
  always_ff @(posedge clock) begin
    if (reset) begin
      err_cnt   <= 16'h0000;
      any_err_d <= 1'b0;
    end else if (!full_state) begin
      any_err_d <= err || len_err;
      if ((err || len_err) && !any_err_d && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'h0001;
      end
    end
  end
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_router_pkt_reg.sv
// Scoreboard bench for router_pkt_reg: drives the one-hot state inputs as the
// router FSM would and checks dout, parity/length flags and the error counter.
module tb_router_pkt_reg;

  logic        clock = 1'b0;
  logic        reset, pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic        laf_state, full_state, rst_int_reg;
  logic [7:0]  data_in, dout;
  logic        parity_done, low_pkt_valid, err, len_err;
  logic [15:0] err_cnt;

  int          n_checks = 0;
  int          n_pass = 0;
  int          exp_err_cnt = 0;
  logic [7:0]  exp_q[$];

  always #5 clock = ~clock;

  router_pkt_reg #(.DATA_W(8), .ADDR_W(2), .ODD_PAR(1'b0)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .len_err(len_err), .err_cnt(err_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic ctl_idle();
    pkt_valid = 1'b0; fifo_full = 1'b0; detect_add = 1'b0; lfd_state = 1'b0;
    ld_state = 1'b0; laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
  endtask

  // one clock; if this beat produces output, pop the scoreboard and compare
  task automatic tick(input bit produces);
    logic [7:0] e;
    @(posedge clock); #1;
    if (produces) begin
      if (exp_q.size() == 0) check_val("sb_nonempty", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check_val("dout", {24'd0, dout}, {24'd0, e});
      end
    end
  endtask

  task automatic send_hdr(input logic [7:0] hdr);
    ctl_idle();
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
    tick(1'b0);
    check_val("hdr_clr_pd", {31'd0, parity_done}, 32'd0);
    check_val("hdr_clr_err", {31'd0, err}, 32'd0);
    check_val("hdr_clr_len", {31'd0, len_err}, 32'd0);
    detect_add = 1'b0; lfd_state = 1'b1; exp_q.push_back(hdr);
    tick(1'b1);
    lfd_state = 1'b0; ld_state = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl [8], input int n,
                          input logic [7:0] par, input int stall_idx, input bit full_par);
    logic [7:0] x;
    bit exp_err, exp_len;
    x = hdr;
    for (int i = 0; i < n; i++) x = x ^ pl[i];
    exp_err = (par != x);
    exp_len = (n != int'(hdr[7:2]));
    send_hdr(hdr);
    for (int i = 0; i < n; i++) begin
      data_in = pl[i];
      if (i == stall_idx) begin
        fifo_full = 1'b1;
        tick(1'b0);
        fifo_full = 1'b0; ld_state = 1'b0; laf_state = 1'b1;
        exp_q.push_back(pl[i]);
        tick(1'b1);
        tick(1'b0);
        check_val("laf_hold_dout", {24'd0, dout}, {24'd0, pl[i]});
        laf_state = 1'b0; ld_state = 1'b1;
      end else begin
        exp_q.push_back(pl[i]);
        tick(1'b1);
      end
    end
    pkt_valid = 1'b0; data_in = par; fifo_full = full_par;
    tick(1'b0);
    if (full_par) begin
      check_val("low_pkt_valid", {31'd0, low_pkt_valid}, 32'd1);
      check_val("pd_deferred", {31'd0, parity_done}, 32'd0);
      ld_state = 1'b0; fifo_full = 1'b0; laf_state = 1'b1;
      tick(1'b0);
      check_val("pd_after_laf", {31'd0, parity_done}, 32'd1);
      laf_state = 1'b0;
    end else begin
      check_val("parity_done", {31'd0, parity_done}, 32'd1);
      ld_state = 1'b0;
    end
    check_val("err_early", {31'd0, err}, 32'd0);
    tick(1'b0);
    check_val("err", {31'd0, err}, {31'd0, exp_err});
    check_val("len_err", {31'd0, len_err}, {31'd0, exp_len});
    if (full_par) begin
      rst_int_reg = 1'b1;
      tick(1'b0);
      check_val("lpv_cleared", {31'd0, low_pkt_valid}, 32'd0);
      rst_int_reg = 1'b0;
    end
    tick(1'b0);
`ifdef ROUTER_PKT_REG_ERR_CNT_EN
    if (exp_err || exp_len) exp_err_cnt++;
`endif
    check_val("err_cnt", {16'd0, err_cnt}, 32'(exp_err_cnt));
  endtask

  initial begin
    logic [7:0] pl [8];
    logic [7:0] good;
    ctl_idle();
    data_in = 8'h00;
    reset = 1'b1;
    tick(1'b0); tick(1'b0);
    reset = 1'b0;
    check_val("rst_dout", {24'd0, dout}, 32'd0);
    check_val("rst_pd", {31'd0, parity_done}, 32'd0);
    check_val("rst_lpv", {31'd0, low_pkt_valid}, 32'd0);
    check_val("rst_err", {30'd0, err, len_err}, 32'd0);
    check_val("rst_err_cnt", {16'd0, err_cnt}, 32'd0);

    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
    good = 8'h16 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55;
    send_pkt(8'h16, pl, 5, good, -1, 1'b0);        // good packet
    send_pkt(8'h16, pl, 5, 8'd46, -1, 1'b0);       // bad parity
    send_pkt(8'h16, pl, 4, good ^ 8'h55, -1, 1'b0); // one payload short, parity matches
    send_pkt(8'h16, pl, 5, good, 2, 1'b0);         // stall on third payload
    send_pkt(8'h16, pl, 5, good, -1, 1'b1);        // fifo full at parity beat

    pl = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h81, 8'h00, 8'h00, 8'h00};
    send_hdr(8'h16);
    data_in = pl[0]; exp_q.push_back(pl[0]); tick(1'b1);
    data_in = pl[1]; exp_q.push_back(pl[1]); tick(1'b1);
    reset = 1'b1; ctl_idle();
    tick(1'b0);
    reset = 1'b0;
    exp_q.delete();
    exp_err_cnt = 0;
    check_val("mid_rst_dout", {24'd0, dout}, 32'd0);
    check_val("mid_rst_flags", {28'd0, parity_done, low_pkt_valid, err, len_err}, 32'd0);
    check_val("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    good = 8'h16 ^ 8'hA5 ^ 8'h3C ^ 8'hF0 ^ 8'h0F ^ 8'h81;
    send_pkt(8'h16, pl, 5, good, -1, 1'b0);

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
